sgf_align_shifter: RTL
======================

SGF_ALIGN_SHIFTER -- requirements
Module: sgf_align_shifter

Interface
REQ-001 Parameter W_Sgf, default 23, stored significand width (23 single, 52 double).
REQ-002 Parameter W_Exp, default 8, exponent-difference width (8 single, 11 double).
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-high.
REQ-005 start  input  1  request to align; sampled only in IDLE.
REQ-006 Sgf_In  input  W_Sgf+1  significand of the smaller operand, hidden bit included.
REQ-007 Shift_Amt  input  W_Exp  exponent difference, i.e. the right-shift count.
REQ-008 busy  output  1  high whenever the FSM is not in IDLE.
REQ-009 done  output  1  one-cycle pulse marking Sgf_Align valid.
REQ-010 Sgf_Align  output  W_Sgf+3  {aligned significand[W_Sgf+2:2], guard[1], sticky[0]}; format consumed by the rounding phase.

Function
REQ-011 FSM states SHALL be IDLE, SHIFT and DONE; IDLE is the reset state.
REQ-012 In IDLE with start=1, on the clock edge: R <= {Sgf_In, 2'b00}; cnt <= min(Shift_Amt, W_Sgf+3); state -> SHIFT.
REQ-013 Clamp: Shift_Amt values greater than or equal to W_Sgf+3 SHALL give cnt = W_Sgf+3; cnt width SHALL hold W_Sgf+3.
REQ-014 SHIFT with cnt != 0: R <= {1'b0, R[W_Sgf+2:2], R[1]|R[0]}; cnt <= cnt-1; remain in SHIFT.
REQ-015 SHIFT with cnt == 0: R unchanged; state -> DONE.
REQ-016 DONE: done=1 for exactly that cycle; state -> IDLE on the next edge.
REQ-017 Latency: with N = clamped count, done SHALL be high N+1 cycles after the edge that sampled start.
REQ-018 Sticky SHALL be the OR of every bit shifted below the guard position and SHALL never clear once set during an operation.
REQ-019 Sgf_Align SHALL be driven directly from R; it is valid while done=1 and holds until the next accepted start.
REQ-020 start while busy=1 (SHIFT or DONE) SHALL be ignored; no queuing. The same-cycle start in DONE is also ignored.
REQ-021 Sgf_In and Shift_Amt SHALL be captured at acceptance only; later input changes SHALL not affect the result.
REQ-022 Full shift-out (N = W_Sgf+3): R[W_Sgf+2:1] = 0 and R[0] = OR(Sgf_In).
REQ-023 Sgf_In = 0 SHALL give Sgf_Align = 0 for any shift count.

Reset
REQ-024 rst=1 SHALL immediately force state=IDLE, R=0, cnt=0, busy=0, done=0 and Sgf_Align=0, independent of clk.
REQ-025 Reset asserted mid-SHIFT or in DONE SHALL abort the operation; no done pulse is produced for it.
REQ-026 After rst deasserts, the first start sampled in IDLE SHALL be accepted normally.

Verification (W_Sgf=23, W_Exp=8)
REQ-027 Sgf_In=24'h800000, Shift_Amt=0 -> done 1 cycle after acceptance, Sgf_Align=26'h2000000.
REQ-028 Sgf_In=24'h800001, Shift_Amt=1 -> done after 2 cycles, Sgf_Align=26'h1000002 (guard=1, sticky=0).
REQ-029 Sgf_In=24'hC00007, Shift_Amt=3 -> done after 4 cycles, Sgf_Align=26'h0600003 (guard=1, sticky=1).
REQ-030 Sgf_In=24'h800000, Shift_Amt=200 -> clamped to 26, done after 27 cycles, Sgf_Align=26'h0000001.
REQ-031 Shift_Amt=10 accepted; start pulsed with new data during SHIFT -> ignored, the original result is delivered and busy stays high throughout.
REQ-032 rst pulsed 3 cycles into a Shift_Amt=10 operation -> outputs 0 asynchronously, no done pulse; the next start completes correctly.

Source files
------------

// File: rtl/sgf_align_shifter_if.sv
// Handshake and data bundle for the significand alignment shifter.
// The master is the requester (it drives start and the operands).
// The slave is the shifter (it returns busy, done and the aligned result).
interface sgf_align_shifter_if #(
  parameter int W_Sgf = 23,
  parameter int W_Exp = 8
);
  logic             start;
  logic [W_Sgf:0]   Sgf_In;
  logic [W_Exp-1:0] Shift_Amt;
  logic             busy;
  logic             done;
  logic [W_Sgf+2:0] Sgf_Align;

  modport master (
    output start,
    output Sgf_In,
    output Shift_Amt,
    input  busy,
    input  done,
    input  Sgf_Align
  );

  modport slave (
    input  start,
    input  Sgf_In,
    input  Shift_Amt,
    output busy,
    output done,
    output Sgf_Align
  );
endinterface

// File: rtl/sgf_align_shifter.sv
// Sequential right-shifter that aligns the smaller operand's significand
// before a floating-point add. It shifts one bit per cycle and keeps
// guard and sticky bits, so the rounding stage sees the exact information
// it needs.
// Result layout is {aligned significand, guard, sticky}.
module sgf_align_shifter #(
  parameter int W_Sgf = 23,
  parameter int W_Exp = 8
) (
  input logic                clk,
  input logic                rst,
  sgf_align_shifter_if.slave bus
);

  // Working register width: significand (hidden bit included) plus guard and sticky.
  localparam int W_R   = W_Sgf + 3;
  // The counter must be able to hold W_R itself, which is the full shift-out count.
  localparam int W_CNT = $clog2(W_R + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [W_R-1:0]   r_q, r_d;
  logic [W_CNT-1:0] cnt_q, cnt_d;

  // Shift counts at or beyond the register width all produce the same full
  // shift-out. Saturating the count bounds the operation at W_R cycles.
  function automatic logic [W_CNT-1:0] clamp_cnt(input logic [W_Exp-1:0] amt);
    if (32'(amt) >= 32'(W_R)) begin
      return W_CNT'(W_R);
    end else begin
      return W_CNT'(amt);
    end
  endfunction

  // One alignment step. The significand moves right by one place.
  // The old guard bit is folded into sticky, and the old sticky is kept,
  // so sticky never clears once it has been set.
  function automatic logic [W_R-1:0] shift_step(input logic [W_R-1:0] r);
    return {1'b0, r[W_R-1:2], r[1] | r[0]};
  endfunction

  // Next-state logic: accept in IDLE, shift until the count runs out, then present the result.
  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          r_d     = {bus.Sgf_In, 2'b00};
          cnt_d   = clamp_cnt(bus.Shift_Amt);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt_q != '0) begin
          r_d   = shift_step(r_q);
          cnt_d = cnt_q - W_CNT'(1);
        end else begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, working register and counter. Reset clears everything, so an in-flight operation is abandoned.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      r_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
    end
  end

  // Status and result come straight from registers.
  // Reset therefore clears them immediately, and the result holds after done.
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = (state_q == DONE);
  assign bus.Sgf_Align = r_q;

endmodule
